// File: rtl/min_max_tracker_pkg.sv
// Shared constants and state encoding for the
// windowed min/max tracker.
package minmax_pkg;
  localparam int DATA_W = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/min_max_tracker_if.sv
// Sample-in / window-result-out bundle
// for min_max_tracker.
interface min_max_tracker_if;
  import minmax_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              clear;
  logic              out_valid;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_min;
  logic              out_eq_all;
  logic              busy;

  modport master (
    output in_valid, in_data, clear,
    input  out_valid, out_max, out_min,
    input  out_eq_all, busy
  );

  modport slave (
    input  in_valid, in_data, clear,
    output out_valid, out_max, out_min,
    output out_eq_all, busy
  );
endinterface

// File: rtl/mag_comp.sv
// 4-bit unsigned magnitude comparator.
// Purely combinational.
module mag_comp (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       A_gt_b,
  output logic       A_lt_b,
  output logic       A_eq_b
);
  assign A_gt_b = (A > B);
  assign A_lt_b = (A < B);
  assign A_eq_b = (A == B);
endmodule

// File: rtl/min_max_tracker.sv
// Running max/min/all-equal over windows
// of COUNT accepted samples.
module min_max_tracker
  import minmax_pkg::*;
#(
  parameter int COUNT = 8
) (
  input logic              clk,
  input logic              rst,
  min_max_tracker_if.slave bus
);
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] cur_max, cur_min;
  logic [DATA_W-1:0] max_nxt, min_nxt;
  logic              cur_eq, eq_nxt;
  logic              acc, done;

  logic hi_gt, hi_eq, hi_lt_unused;
  logic lo_lt, lo_eq, lo_gt_unused;

  mag_comp cmp_hi (
    .A      (bus.in_data),
    .B      (cur_max),
    .A_gt_b (hi_gt),
    .A_lt_b (hi_lt_unused),
    .A_eq_b (hi_eq)
  );

  mag_comp cmp_lo (
    .A      (bus.in_data),
    .B      (cur_min),
    .A_gt_b (lo_gt_unused),
    .A_lt_b (lo_lt),
    .A_eq_b (lo_eq)
  );

  assign acc = bus.in_valid & ~bus.clear;

  // Datapath: the first sample seeds the window
  always_comb begin
    max_nxt = cur_max;
    min_nxt = cur_min;
    eq_nxt  = cur_eq;
    cnt_nxt = cnt;
    unique case (state)
      ST_EMPTY: begin
        max_nxt = bus.in_data;
        min_nxt = bus.in_data;
        eq_nxt  = 1'b1;
        cnt_nxt = CW'(1);
      end
      ST_ACCUM: begin
        if (hi_gt) max_nxt = bus.in_data;
        if (lo_lt) min_nxt = bus.in_data;
        eq_nxt  = cur_eq & hi_eq & lo_eq;
        cnt_nxt = cnt + CW'(1);
      end
      default: ;
    endcase
    done = acc & (cnt_nxt == LAST);
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear)
      state_nxt = ST_EMPTY;
    else if (bus.in_valid)
      state_nxt = done ? ST_EMPTY : ST_ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_EMPTY;
      cnt            <= '0;
      cur_max        <= '0;
      cur_min        <= '0;
      cur_eq         <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_max    <= '0;
      bus.out_min    <= '0;
      bus.out_eq_all <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.out_valid <= done;
      bus.busy      <= (state_nxt == ST_ACCUM);
      if (bus.clear) begin
        cnt <= '0;
      end else if (acc) begin
        cnt     <= done ? '0 : cnt_nxt;
        cur_max <= max_nxt;
        cur_min <= min_nxt;
        cur_eq  <= eq_nxt;
      end
      if (done) begin
        bus.out_max    <= max_nxt;
        bus.out_min    <= min_nxt;
        bus.out_eq_all <= eq_nxt;
      end
    end
  end
endmodule
